// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP add/round sequencing controller.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_OVF = 4;
    localparam int FLAG_UNF = 3;
    localparam int FLAG_INX = 2;
    localparam int FLAG_DBZ = 1;
    localparam int FLAG_INV = 0;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RZ  = 2'b01;
    localparam logic [1:0] RM_RU  = 2'b10;
    localparam logic [1:0] RM_RD  = 2'b11;

endpackage

// File: rtl/fpu_flag_reg.sv
// Sticky IEEE exception flags (clear-then-OR on capture) and OVF/UNF trap enables.
module fpu_flag_reg
    import fpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic       cfg_ovf_en,
    input  logic       cfg_unf_en,
    input  logic       flags_clr,
    input  logic       capture,
    input  logic [4:0] ieee,
    output logic       ovf_en,
    output logic       unf_en,
    output logic [4:0] sticky_flags
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_en <= 1'b0;
            unf_en <= 1'b0;
        end else if (cfg_we) begin
            ovf_en <= cfg_ovf_en;
            unf_en <= cfg_unf_en;
        end
    end

    // A clear coincident with a capture keeps only the new op's flags.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_flags <= '0;
        else if (capture)
            sticky_flags <= (flags_clr ? 5'd0 : sticky_flags) | ieee;
        else if (flags_clr)
            sticky_flags <= '0;
    end

endmodule

// File: rtl/fpu_add_ctrl.sv
// Sequencer for the combinational FP add/round datapath: accept, hold operands
// for SETTLE_CYCLES, capture result/flags, hand back over a valid/ready channel.
module fpu_add_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_fpa,
    input  logic [63:0] req_fpb,
    input  logic        req_db,
    input  logic        req_sub,
    input  logic [1:0]  req_rm,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_fp,
    output logic [4:0]  resp_ieee,
    output logic        resp_trap,
    input  logic        cfg_we,
    input  logic        cfg_ovf_en,
    input  logic        cfg_unf_en,
    input  logic        flags_clr,
    output logic [4:0]  sticky_flags,
    output logic        busy,
    output logic [63:0] dp_fpa,
    output logic [63:0] dp_fpb,
    output logic        dp_db,
    output logic        dp_sub,
    output logic        dp_normal,
    output logic [1:0]  dp_rm,
    output logic        dp_ovf_en,
    output logic        dp_unf_en,
    input  logic [63:0] dp_fp,
    input  logic [4:0]  dp_ieee
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       accept, capture;
    logic       ovf_en, unf_en;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = EXEC;
            EXEC:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = req_valid ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) || (state == RESP && resp_ready);
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    assign accept    = req_valid & req_ready;
    assign capture   = (state == EXEC) && (cnt == 4'd0);
    assign dp_normal = 1'b1;

    // Operands are loaded only on accept, so they stay frozen through the settle window.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_fpa    <= '0;
            dp_fpb    <= '0;
            dp_db     <= 1'b0;
            dp_sub    <= 1'b0;
            dp_rm     <= '0;
            dp_ovf_en <= 1'b0;
            dp_unf_en <= 1'b0;
            cnt       <= '0;
            resp_fp   <= '0;
            resp_ieee <= '0;
            resp_trap <= 1'b0;
        end else begin
            if (accept) begin
                dp_fpa    <= req_fpa;
                dp_fpb    <= req_fpb;
                dp_db     <= req_db;
                dp_sub    <= req_sub;
                dp_rm     <= req_rm;
                dp_ovf_en <= ovf_en;
                dp_unf_en <= unf_en;
                cnt       <= CNT_LOAD;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                resp_fp   <= dp_fp;
                resp_ieee <= dp_ieee;
                resp_trap <= (dp_ieee[FLAG_OVF] & dp_ovf_en) | (dp_ieee[FLAG_UNF] & dp_unf_en);
            end
        end
    end

    fpu_flag_reg u_flags (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_ovf_en   (cfg_ovf_en),
        .cfg_unf_en   (cfg_unf_en),
        .flags_clr    (flags_clr),
        .capture      (capture),
        .ieee         (dp_ieee),
        .ovf_en       (ovf_en),
        .unf_en       (unf_en),
        .sticky_flags (sticky_flags)
    );

endmodule

// File: tb/tb_fpu_add_ctrl.sv
// Bench for fpu_add_ctrl: stub datapath, table vectors, corner sequences, random ops.
module tb_fpu_add_ctrl;

    localparam int SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_fpa, req_fpb;
    logic        req_db, req_sub;
    logic [1:0]  req_rm;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_fp;
    logic [4:0]  resp_ieee;
    logic        resp_trap;
    logic        cfg_we, cfg_ovf_en, cfg_unf_en, flags_clr;
    logic [4:0]  sticky_flags;
    logic        busy;
    logic [63:0] dp_fpa, dp_fpb;
    logic        dp_db, dp_sub, dp_normal;
    logic [1:0]  dp_rm;
    logic        dp_ovf_en, dp_unf_en;
    logic [63:0] dp_fp;
    logic [4:0]  dp_ieee;

    always #5 clk = ~clk;

    fpu_add_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fpa(req_fpa), .req_fpb(req_fpb), .req_db(req_db), .req_sub(req_sub), .req_rm(req_rm),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_fp(resp_fp), .resp_ieee(resp_ieee), .resp_trap(resp_trap),
        .cfg_we(cfg_we), .cfg_ovf_en(cfg_ovf_en), .cfg_unf_en(cfg_unf_en),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags), .busy(busy),
        .dp_fpa(dp_fpa), .dp_fpb(dp_fpb), .dp_db(dp_db), .dp_sub(dp_sub), .dp_normal(dp_normal),
        .dp_rm(dp_rm), .dp_ovf_en(dp_ovf_en), .dp_unf_en(dp_unf_en),
        .dp_fp(dp_fp), .dp_ieee(dp_ieee)
    );

    // Stub datapath: a few known IEEE results, otherwise an operand hash so that
    // any operand change during the settle window alters the captured result.
    function automatic logic [68:0] dp_func(logic [63:0] a, logic [63:0] b, logic db, logic sub, logic [1:0] rm);
        if (db && !sub && a == 64'h3FF0000000000000 && b == 64'h4000000000000000)
            return {64'h4008000000000000, 5'b00000};
        if (db && !sub && a == 64'h7FEFFFFFFFFFFFFF && b == 64'h7FEFFFFFFFFFFFFF)
            return {64'h7FF0000000000000, 5'b10100};
        if (!db && sub && a[31:0] == 32'h3F800000 && b[31:0] == 32'h3F800000)
            return {64'h0, 5'b00000};
        if (db && !sub && a == 64'h3FF0000000000000 && b == 64'h3CA0000000000000)
            return {64'h3FF0000000000000, 5'b00100};
        if (a == 64'hDEAD)
            return {64'h7FF0000000000000, 5'b10000};
        return {a ^ {b[31:0], b[63:32]} ^ {62'd0, rm} ^ (sub ? 64'hFFFF : 64'h0) ^ {db, 63'd0},
                a[4:0] ^ b[9:5] ^ {3'b000, rm}};
    endfunction

    always_comb {dp_fp, dp_ieee} = dp_func(dp_fpa, dp_fpb, dp_db, dp_sub, dp_rm);

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: sticky flags and trap enables as seen from outside.
    logic [4:0] m_sticky = '0;
    logic       m_ovf = 1'b0, m_unf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Issue one op at a negedge (DUT idle, or in RESP when b2b) and leave the DUT in RESP.
    task automatic do_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic db, input logic sub, input logic [1:0] rm,
                         input logic [63:0] efp, input logic [4:0] eieee,
                         input bit b2b, input bit cfg_acc, input bit co, input bit cu,
                         input bit clr_cap);
        logic op_ovf, op_unf;
        int k;
        req_valid = 1'b1; req_fpa = a; req_fpb = b; req_db = db; req_sub = sub; req_rm = rm;
        if (b2b) resp_ready = 1'b1;
        if (cfg_acc) begin cfg_we = 1'b1; cfg_ovf_en = co; cfg_unf_en = cu; end
        #1;
        chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
        op_ovf = m_ovf; op_unf = m_unf;
        if (cfg_acc) begin m_ovf = co; m_unf = cu; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0; cfg_we = 1'b0;
        chk({nm, " busy"}, 64'(busy), 64'd1);
        chk({nm, " dp_fpa"}, dp_fpa, a);
        k = 0;
        while (!resp_valid && k < 40) begin
            if (clr_cap && k == SETTLE - 1) flags_clr = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flags_clr = 1'b0;
            k++;
        end
        chk({nm, " latency"}, 64'(k), 64'(SETTLE));
        m_sticky = (clr_cap ? 5'd0 : m_sticky) | eieee;
        chk({nm, " resp_fp"}, resp_fp, efp);
        chk({nm, " resp_ieee"}, 64'(resp_ieee), 64'(eieee));
        chk({nm, " resp_trap"}, 64'(resp_trap), 64'((eieee[4] & op_ovf) | (eieee[3] & op_unf)));
        chk({nm, " sticky"}, 64'(sticky_flags), 64'(m_sticky));
    endtask

    task automatic release_resp(input string nm);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, " idle after take"}, 64'({resp_valid, busy}), 64'd0);
    endtask

    task automatic cfg_write(input bit co, input bit cu);
        cfg_we = 1'b1; cfg_ovf_en = co; cfg_unf_en = cu;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        m_ovf = co; m_unf = cu;
    endtask

    typedef struct {
        string       nm;
        logic [63:0] a, b;
        logic        db, sub;
        logic [1:0]  rm;
        logic [63:0] efp;
        logic [4:0]  eieee;
        bit          ovf_en;
    } vec_t;

    vec_t vt[3];

    initial begin
        logic [63:0] held;
        logic [68:0] r;
        bit pending;

        vt[0] = '{"dadd", 64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 2'b00,
                  64'h4008000000000000, 5'b00000, 1'b0};
        vt[1] = '{"dovf", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b1, 1'b0, 2'b00,
                  64'h7FF0000000000000, 5'b10100, 1'b1};
        vt[2] = '{"ssub", 64'h3F800000, 64'h3F800000, 1'b0, 1'b1, 2'b00,
                  64'h0, 5'b00000, 1'b1};

        rst = 1'b1; req_valid = 0; req_fpa = 0; req_fpb = 0; req_db = 0; req_sub = 0; req_rm = 0;
        resp_ready = 0; cfg_we = 0; cfg_ovf_en = 0; cfg_unf_en = 0; flags_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst sticky", 64'(sticky_flags), 64'd0);
        chk("rst dp_normal", 64'(dp_normal), 64'd1);
        chk("rst dp_fpa", dp_fpa, 64'd0);
        chk("rst resp_fp", resp_fp, 64'd0);

        foreach (vt[i]) begin
            if (vt[i].ovf_en != m_ovf) cfg_write(vt[i].ovf_en, 1'b0);
            do_op(vt[i].nm, vt[i].a, vt[i].b, vt[i].db, vt[i].sub, vt[i].rm,
                  vt[i].efp, vt[i].eieee, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            release_resp(vt[i].nm);
        end

        flags_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flags_clr = 1'b0;
        m_sticky = '0;
        chk("clear sticky", 64'(sticky_flags), 64'd0);

        // Back-to-back: the second request is taken on the edge that retires the first.
        do_op("b2b first", vt[0].a, vt[0].b, 1'b1, 1'b0, 2'b00, vt[0].efp, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("b2b second", 64'h3F800000, 64'h3F800000, 1'b0, 1'b1, 2'b00, 64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: response held, new requests and operand changes ignored.
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_fpa = {$urandom, $urandom};
            #1;
            chk("bp req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
            chk("bp resp_valid", 64'(resp_valid), 64'd1);
            chk("bp resp_fp", resp_fp, 64'h0);
            chk("bp dp_fpa", dp_fpa, 64'h3F800000);
        end
        req_valid = 1'b0;
        release_resp("bp");

        // Clear landing on the capture edge keeps only the new op's INX.
        do_op("pre ovf", 64'hDEAD, 64'h1, 1'b0, 1'b0, 2'b00, 64'h7FF0000000000000, 5'b10000,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        release_resp("pre ovf");
        chk("pre sticky", 64'(sticky_flags), 64'h10);
        do_op("clr on cap", 64'h3FF0000000000000, 64'h3CA0000000000000, 1'b1, 1'b0, 2'b00,
              64'h3FF0000000000000, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        release_resp("clr on cap");

        // Random ops with cfg writes on the accept edge and random chaining.
        pending = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a, b;
            logic db, sub;
            logic [1:0] rm;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            db = 1'($urandom); sub = 1'($urandom); rm = 2'($urandom);
            r = dp_func(a, b, db, sub, rm);
            do_op("rand", a, b, db, sub, rm, r[68:5], r[4:0], pending,
                  ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
            pending = 1'($urandom);
            if (!pending) release_resp("rand");
        end
        if (pending) release_resp("rand last");

        // Reset mid-EXEC abandons the op silently.
        flags_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flags_clr = 1'b0;
        held = 64'h3FF0000000000000;
        req_valid = 1'b1; req_fpa = held; req_fpb = 64'h3CA0000000000000; req_db = 1'b1; req_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_sticky = '0; m_ovf = 1'b0; m_unf = 1'b0;
        chk("rst exec busy", 64'(busy), 64'd0);
        chk("rst exec resp_valid", 64'(resp_valid), 64'd0);
        chk("rst exec sticky", 64'(sticky_flags), 64'd0);
        chk("rst exec dp_fpa", dp_fpa, 64'd0);
        for (int c = 0; c < SETTLE + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst exec no resp", 64'({resp_valid, sticky_flags}), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/fpu_add_ctrl.md
Name: fpu_add_ctrl

Overview:
Sequencing controller for the combinational FP add/round datapath (unpacker → adder → rounder, exposed as the `master` block).
- Accepts one add/sub request at a time over a valid/ready handshake.
- Holds the operands stable on the datapath inputs for a programmable multicycle settle window, then captures the result and IEEE flags.
- Returns the result over a valid/ready response channel.
- Owns the sticky exception-flag register and the OVF/UNF trap-enable configuration that the datapath currently ties off.

Parameters:
SETTLE_CYCLES, 3, cycles operands are held on the datapath before capture; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  controller can accept
req_fpa  in  64  operand A (single precision in [31:0] when req_db=0)
req_fpb  in  64  operand B
req_db  in  1  1=double, 0=single
req_sub  in  1  1=A−B, 0=A+B
req_rm  in  2  rounding mode: 00 RNE, 01 RZ, 10 RU, 11 RD
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_fp  out  64  rounded result
resp_ieee  out  5  flags of this op: [4]OVF [3]UNF [2]INX [1]DBZ [0]INV
resp_trap  out  1  (OVF&ovf_en)|(UNF&unf_en) for this op
cfg_we  in  1  write trap enables
cfg_ovf_en  in  1  OVF trap enable value
cfg_unf_en  in  1  UNF trap enable value
flags_clr  in  1  clear sticky flags
sticky_flags  out  5  OR of resp_ieee since reset/clear
busy  out  1  state != IDLE
dp_fpa, dp_fpb  out  64  datapath operands (registered)
dp_db, dp_sub, dp_normal  out  1  datapath controls (registered); dp_normal is always 1
dp_rm  out  2  datapath rounding mode
dp_ovf_en, dp_unf_en  out  1  trap enables latched at accept
dp_fp  in  64  datapath result
dp_ieee  in  5  datapath flags

Behaviour:
- Reset (synchronous, active-high): state IDLE; all dp_* operand/control regs 0 except dp_normal=1; resp_fp=0, resp_ieee=0, resp_valid=0, resp_trap=0; sticky_flags=0; ovf_en=unf_en=0; counter=0. Reset during EXEC or RESP abandons the op with no response and no flag update.
- States:
  - IDLE: req_ready=1.
  - EXEC: counter runs.
  - RESP: resp_valid=1.
- req_ready = (state==IDLE) | (state==RESP & resp_ready).
- Accept (req_valid & req_ready): on that edge register the req_* fields into dp_*, latch current ovf_en/unf_en into dp_ovf_en/dp_unf_en, load counter=SETTLE_CYCLES−1, go to EXEC.
- EXEC:
  - counter≠0: decrement.
  - counter==0: capture dp_fp→resp_fp, dp_ieee→resp_ieee, compute resp_trap, sticky_flags |= dp_ieee, go to RESP.
  - Net effect: resp_valid rises SETTLE_CYCLES edges after the accept edge.
- RESP: outputs held stable until resp_ready.
  - resp_ready & req_valid: accept the new request on the same edge and go to EXEC (back-to-back; throughput 1 op per SETTLE_CYCLES+1 cycles).
  - resp_ready & !req_valid: go to IDLE.
- dp_* inputs do not change between accept and capture. Requests presented while busy are ignored (req_ready=0).
- cfg_we: updates ovf_en/unf_en in any state. An in-flight op uses the values latched at accept. A cfg write on the accept edge is not seen by that op.
- flags_clr on the same edge as a capture: sticky_flags = dp_ieee (the clear applies first, then the OR). flags_clr alone: sticky_flags=0.
- Counter width 4 bits. No arithmetic beyond decrement-to-zero; no wrap.

Decomposition:
- fpu_ctrl_pkg: state enum (IDLE, EXEC, RESP), flag bit index constants (OVF=4, UNF=3, INX=2, DBZ=1, INV=0), RM encoding constants.
- Sub-module fpu_flag_reg: sticky flags with clear-then-OR priority and trap-enable registers.

Test Plan:
1. Double add 0x3FF0000000000000 + 0x4000000000000000, RM=00, SETTLE=3 → resp_valid 3 edges after accept, resp_fp=0x4008000000000000, resp_ieee=0, sticky=0.
2. Double 0x7FEFFFFFFFFFFFFF + same, RM=00, ovf_en=1 → resp_fp=0x7FF0000000000000, resp_ieee=10100b, resp_trap=1, sticky=10100b; then flags_clr → sticky=0.
3. Back-to-back: resp_ready and req_valid both high in RESP (single 0x3F800000 − 0x3F800000, sub=1) → accepted same edge, resp_fp[31:0]=0x00000000, no idle cycle.
4. Backpressure: resp_ready=0 for 10 cycles → resp_* stable, req_ready=0, changing req_fpa has no effect on dp_fpa.
5. rst asserted mid-EXEC → next cycle IDLE, resp_valid=0, sticky unchanged from pre-op value 0, no response emitted.
6. flags_clr on capture edge of an op returning INX (00100b) with prior sticky 10000b → sticky=00100b.
